soc_msp430_trace_monitor: RTL and testbench

SOC_MSP430_TRACE_MONITOR -- requirements
Module: soc_msp430_trace_monitor

---
 rtl/soc_msp430_trace_monitor.sv | 138 +++++++++++++
 tb/tb_soc_msp430_trace_monitor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/soc_msp430_trace_monitor.sv
// Trace monitor for a simulated MSP430-style core.
// Watches the retirement trace for simulation-control NOPs (upper half == MAGIC)
// and turns them into exit, putc and marker events, using a shadow copy of r3
// as the argument register.
module soc_msp430_trace_monitor #(
    parameter int unsigned ID         = 0,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] MAGIC      = 16'h1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trace_valid,
    input  logic [31:0] trace_pc,
    input  logic [31:0] trace_insn,
    input  logic        trace_wb,
    input  logic [4:0]  trace_wb_reg,
    input  logic [31:0] trace_wb_data,
    output logic        char_valid,
    input  logic        char_ready,
    output logic [7:0]  char_data,
    output logic        termination,
    output logic [31:0] exit_code,
    output logic        marker,
    output logic [15:0] marker_id,
    output logic [31:0] insn_cnt,
    output logic [7:0]  overflow_cnt,
    output logic [15:0] core_id
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DepthC = (AW + 1)'(FIFO_DEPTH);

    localparam logic [15:0] CodeExit   = 16'h0001;
    localparam logic [15:0] CodePutc   = 16'h0004;
    localparam logic [15:0] CodeMarker = 16'h0020;

    // The PC is part of the trace bundle but carries no information we act on.
    logic unused_pc;
    assign unused_pc = ^trace_pc;

    logic [31:0]   shadow_q, shadow_d;
    logic          term_q, term_d;
    logic [31:0]   exit_q, exit_d;
    logic          marker_q, marker_d;
    logic [15:0]   marker_id_q, marker_id_d;
    logic [31:0]   insn_cnt_q, insn_cnt_d;
    logic [7:0]    ovf_q, ovf_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic        wb_r3;
    logic [31:0] eff_r3;
    logic        special;
    logic        do_exit, do_putc, do_marker;
    logic        full, pop, push_acc, drop;

    // Decode of the retiring instruction and FIFO handshake.
    always_comb begin
        wb_r3     = trace_valid && trace_wb && (trace_wb_reg == 5'd3) && !term_q;
        // Same-cycle r3 writeback is bypassed so "mov #x, r3; special" pairs work.
        eff_r3    = wb_r3 ? trace_wb_data : shadow_q;
        special   = trace_valid && (trace_insn[31:16] == MAGIC) && !term_q;
        do_exit   = special && (trace_insn[15:0] == CodeExit);
        do_putc   = special && (trace_insn[15:0] == CodePutc);
        do_marker = special && (trace_insn[15:0] == CodeMarker);
        full      = (count_q == DepthC);
        pop       = char_valid && char_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_acc  = do_putc && (!full || pop);
        drop      = do_putc && full && !pop;
    end

    // Next-state for all registered state.
    always_comb begin
        shadow_d    = wb_r3 ? trace_wb_data : shadow_q;
        term_d      = term_q || do_exit;
        exit_d      = do_exit ? eff_r3 : exit_q;
        marker_d    = do_marker;
        marker_id_d = do_marker ? eff_r3[15:0] : marker_id_q;
        insn_cnt_d  = (trace_valid && !term_q) ? insn_cnt_q + 32'd1 : insn_cnt_q;
        ovf_d       = (drop && (ovf_q != 8'hff)) ? ovf_q + 8'd1 : ovf_q;
        wr_ptr_d    = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q;
        if (push_acc && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_acc && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q    <= '0;
            term_q      <= 1'b0;
            exit_q      <= '0;
            marker_q    <= 1'b0;
            marker_id_q <= '0;
            insn_cnt_q  <= '0;
            ovf_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            shadow_q    <= shadow_d;
            term_q      <= term_d;
            exit_q      <= exit_d;
            marker_q    <= marker_d;
            marker_id_q <= marker_id_d;
            insn_cnt_q  <= insn_cnt_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= eff_r3[7:0];
        end
    end

    assign char_valid   = (count_q != '0);
    assign char_data    = char_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign termination  = term_q;
    assign exit_code    = exit_q;
    assign marker       = marker_q;
    assign marker_id    = marker_id_q;
    assign insn_cnt     = insn_cnt_q;
    assign overflow_cnt = ovf_q;
    assign core_id      = 16'(ID);

endmodule

// File: tb/tb_soc_msp430_trace_monitor.sv
// Directed bench for soc_msp430_trace_monitor: putc/FIFO, overflow, exit,
// marker and asynchronous reset behaviour with hand-computed expectations.
module tb_soc_msp430_trace_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trace_valid = 1'b0;
    logic [31:0] trace_pc = '0;
    logic [31:0] trace_insn = '0;
    logic        trace_wb = 1'b0;
    logic [4:0]  trace_wb_reg = '0;
    logic [31:0] trace_wb_data = '0;
    logic        char_valid;
    logic        char_ready = 1'b0;
    logic [7:0]  char_data;
    logic        termination;
    logic [31:0] exit_code;
    logic        marker;
    logic [15:0] marker_id;
    logic [31:0] insn_cnt;
    logic [7:0]  overflow_cnt;
    logic [15:0] core_id;

    int passed = 0;
    int total  = 0;

    soc_msp430_trace_monitor #(
        .ID        (16'h0007),
        .FIFO_DEPTH(4),
        .MAGIC     (16'h1500)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .trace_valid  (trace_valid),
        .trace_pc     (trace_pc),
        .trace_insn   (trace_insn),
        .trace_wb     (trace_wb),
        .trace_wb_reg (trace_wb_reg),
        .trace_wb_data(trace_wb_data),
        .char_valid   (char_valid),
        .char_ready   (char_ready),
        .char_data    (char_data),
        .termination  (termination),
        .exit_code    (exit_code),
        .marker       (marker),
        .marker_id    (marker_id),
        .insn_cnt     (insn_cnt),
        .overflow_cnt (overflow_cnt),
        .core_id      (core_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Retire one instruction, optionally with a register writeback.
    task automatic issue(input logic [31:0] insn, input logic wb, input logic [4:0] reg_idx,
                         input logic [31:0] data);
        trace_valid   = 1'b1;
        trace_pc      = trace_pc + 32'd2;
        trace_insn    = insn;
        trace_wb      = wb;
        trace_wb_reg  = reg_idx;
        trace_wb_data = data;
        step();
        trace_valid   = 1'b0;
        trace_wb      = 1'b0;
    endtask

    initial begin
        // Reset state.
        #1 rst = 1'b1;
        #2;
        chk("rst_char_valid", 32'(char_valid), 32'd0);
        chk("rst_char_data", 32'(char_data), 32'd0);
        chk("rst_term", 32'(termination), 32'd0);
        chk("rst_exit_code", exit_code, 32'd0);
        chk("rst_marker", 32'(marker), 32'd0);
        chk("rst_insn_cnt", insn_cnt, 32'd0);
        chk("rst_overflow", 32'(overflow_cnt), 32'd0);
        chk("core_id", 32'(core_id), 32'h0007);
        step();
        step();
        rst = 1'b0;
        step();

        // Single putc with consumer ready.
        char_ready = 1'b1;
        issue(32'h0000_4034, 1'b1, 5'd3, 32'h41);
        issue(32'h1500_0004, 1'b0, 5'd0, 32'h0);
        chk("putc_valid", 32'(char_valid), 32'd1);
        chk("putc_data", 32'(char_data), 32'h41);
        step();
        chk("putc_one_cycle", 32'(char_valid), 32'd0);
        chk("cnt_after_putc", insn_cnt, 32'd2);

        // Five putcs into a depth-4 FIFO with r3 bypassed in the same cycle.
        char_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue(32'h1500_0004, 1'b1, 5'd3, 32'h30 + 32'(i));
        end
        chk("ovf_one", 32'(overflow_cnt), 32'd1);
        char_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_%0d", k), 32'(char_data), 32'h30 + 32'(k));
            step();
        end
        chk("drain_empty", 32'(char_valid), 32'd0);
        chk("cnt_after_burst", insn_cnt, 32'd7);

        // Full FIFO with simultaneous push and pop: no drop, new char last.
        char_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(32'h1500_0004, 1'b1, 5'd3, 32'h50 + 32'(i));
        end
        char_ready = 1'b1;
        issue(32'h1500_0004, 1'b1, 5'd3, 32'h54);
        chk("pp_ovf_same", 32'(overflow_cnt), 32'd1);
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("pp_order_%0d", k), 32'(char_data), 32'h50 + 32'(k));
            step();
        end
        chk("pp_empty", 32'(char_valid), 32'd0);

        // Marker pulse, then codes and prefixes that must do nothing.
        issue(32'h0000_4035, 1'b1, 5'd3, 32'h0000_1234);
        issue(32'h1500_0020, 1'b0, 5'd0, 32'h0);
        chk("marker_hi", 32'(marker), 32'd1);
        chk("marker_id", 32'(marker_id), 32'h1234);
        step();
        chk("marker_lo", 32'(marker), 32'd0);
        issue(32'h1500_0002, 1'b0, 5'd0, 32'h0);
        issue(32'h1501_0004, 1'b0, 5'd0, 32'h0);
        chk("other_no_char", 32'(char_valid), 32'd0);
        chk("other_no_term", 32'(termination), 32'd0);
        chk("cnt_before_exit", insn_cnt, 32'd16);

        // Queue three chars, exit with bypassed r3, then ignored specials.
        char_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(32'h1500_0004, 1'b1, 5'd3, 32'h61 + 32'(i));
        end
        issue(32'h1500_0001, 1'b1, 5'd3, 32'h2A);
        chk("term_set", 32'(termination), 32'd1);
        chk("exit_code", exit_code, 32'h2A);
        chk("cnt_exit_counted", insn_cnt, 32'd20);
        issue(32'h1500_0004, 1'b1, 5'd3, 32'h77);
        issue(32'h1500_0020, 1'b0, 5'd0, 32'h0);
        chk("post_marker", 32'(marker), 32'd0);
        chk("post_marker_id", 32'(marker_id), 32'h1234);
        chk("post_exit_code", exit_code, 32'h2A);
        chk("post_cnt_frozen", insn_cnt, 32'd20);
        chk("post_head", 32'(char_data), 32'h61);
        // FIFO still drains after termination.
        char_ready = 1'b1;
        step();
        char_ready = 1'b0;
        chk("post_drain", 32'(char_data), 32'h62);
        step();
        chk("post_hold", 32'(char_data), 32'h62);

        // Asynchronous reset between edges with two chars queued.
        #2 rst = 1'b1;
        #1;
        chk("arst_term", 32'(termination), 32'd0);
        chk("arst_valid", 32'(char_valid), 32'd0);
        chk("arst_cnt", insn_cnt, 32'd0);
        chk("arst_exit", exit_code, 32'd0);
        chk("arst_marker_id", 32'(marker_id), 32'd0);
        chk("arst_core_id", 32'(core_id), 32'h0007);
        step();
        rst = 1'b0;
        step();
        // Shadow r3 was cleared, so putc without writeback emits 0x00.
        issue(32'h1500_0004, 1'b0, 5'd0, 32'h0);
        chk("shadow_clr_valid", 32'(char_valid), 32'd1);
        chk("shadow_clr_data", 32'(char_data), 32'h00);
        chk("cnt_restart", insn_cnt, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
